multi_cycle_control_unit: RTL and testbench
===========================================

MULTI_CYCLE_CONTROL_UNIT -- requirements
Module: multi_cycle_control_unit

Interface
REQ-001 Parameter OPW, default 6: opcode width in bits.
REQ-002 Parameter ALUOPW, default 3: ALUOp width in bits.
REQ-003 Parameter MEM_TIMEOUT, default 15: maximum number of MEM-state cycles allowed without mem_ready; must be ≥1.
REQ-004 CLK  in  1  system clock; all state updates on rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
REQ-006 opcode  in  OPW  opcode field of the instruction register.
REQ-007 zero  in  1  ALU zero flag, valid in EXE.
REQ-008 mem_ready  in  1  data memory done, sampled in MEM.
REQ-009 PCWre  out  1  PC load enable.
REQ-010 IRWre  out  1  instruction register load enable.
REQ-011 ExtSel  out  1  1 = sign-extend, 0 = zero-extend.
REQ-012 RegOut  out  1  destination register select: 0 = rt, 1 = rd.
REQ-013 RegWre  out  1  register file write enable.
REQ-014 ALUOp  out  ALUOPW  ALU function: 000 add, 001 sub, 011 or, 100 and.
REQ-015 ALUSrcB  out  1  ALU operand B select: 1 = immediate, 0 = rt.
REQ-016 ALUM2Reg  out  1  write-back select: 1 = memory data.
REQ-017 PCSrc  out  2  next-PC select: 00 = PC+4, 01 = branch target, 10 = jump target.
REQ-018 DataMemWr  out  1  data memory write strobe.
REQ-019 DataMemRd  out  1  data memory read strobe.
REQ-020 state  out  3  current FSM state, for debug.
REQ-021 halted  out  1  1 while in HALT.
REQ-022 mem_err  out  1  sticky flag: memory timeout occurred.
REQ-023 illegal  out  1  sticky flag: undefined opcode was decoded.

Function
REQ-024 Opcodes:
- add 000000, addi 000001, sub 000010
- ori 010000, and 010001, or 010010
- move 100000, sw 100110, lw 100111
- beq 110000, bne 110001, j 111000, halt 111111
REQ-025 State encoding: IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=101; state is registered, outputs are combinational from state and opcode.
REQ-026 Transitions:
- IF→ID always.
- ID: halt→HALT; j→IF; undefined opcode→IF; all others→EXE.
- EXE: beq/bne→IF; sw/lw→MEM; all other instructions→WB.
- MEM: if mem_ready=0, stay in MEM; if mem_ready=1, sw→IF and lw→WB.
- WB→IF.
- HALT→HALT until Reset.
REQ-027 IRWre=1 only in IF.
REQ-028 PCWre=1 for exactly one cycle per instruction, in its final state:
- ID for j and for undefined opcodes (PCSrc=10 for j, 00 otherwise).
- EXE for beq/bne.
- MEM on the mem_ready cycle for sw.
- WB for all writing instructions.
REQ-029 Branch PCSrc in EXE: beq gives 01 if zero=1, else 00; bne gives 01 if zero=0, else 00.
REQ-030 RegWre=1 only in WB; RegOut=1 for add, sub, and, or, move, and 0 otherwise.
REQ-031 ALUM2Reg=1 only for lw, held from MEM through WB.
REQ-032 DataMemWr=1 for sw in every MEM cycle; DataMemRd=1 for lw in every MEM cycle.
REQ-033 Per-opcode datapath signals, held in every state:
- ExtSel=0 for ori, and, or; 1 otherwise.
- ALUSrcB=1 for addi, ori, lw, sw.
- ALUOp=001 for sub, beq, bne; 011 for ori, or; 100 for and; 000 otherwise.
REQ-034 Memory wait counter:
- Width is clog2(MEM_TIMEOUT+1).
- Cleared on entry to MEM; increments each MEM cycle with mem_ready=0.
- When the count reaches MEM_TIMEOUT with mem_ready=0: mem_err←1, next state HALT, no PCWre, no RegWre.
REQ-035 mem_ready=1 on the same cycle the counter reaches MEM_TIMEOUT counts as success; ready wins.
REQ-036 illegal←1 on the ID cycle that decodes an undefined opcode; that instruction then executes as a no-op.
REQ-037 In HALT, all enables and strobes are 0 and halted=1.

Reset
REQ-038 While Reset=1 on a rising edge:
- state←IF; counter←0; mem_err←0; illegal←0.
REQ-039 While Reset=1, PCWre, IRWre, RegWre, DataMemWr and DataMemRd are forced to 0 regardless of state.
REQ-040 Reset asserted in any state, including MEM mid-access and HALT, aborts the instruction with no further writes; the first cycle after release is IF.

Verification
REQ-041 add, with reset released: IF→ID→EXE→WB→IF over 4 cycles; RegWre=1 and RegOut=1 only in WB; PCWre=1 only in WB.
REQ-042 lw with mem_ready=1 after 3 MEM cycles: 7 cycles total; DataMemRd=1 for 3 cycles; WB has ALUM2Reg=1 and RegWre=1.
REQ-043 beq with zero=1, then bne with zero=1: each takes 3 cycles; PCSrc=01 then 00 in EXE; RegWre stays 0.
REQ-044 sw with mem_ready held 0 and MEM_TIMEOUT=15: after 15 MEM cycles, state=HALT, mem_err=1, no PCWre; Reset then clears mem_err and returns to IF.
REQ-045 Opcode 000111, then j: illegal=1 after ID with PCWre=1 and PCSrc=00; the j completes in 2 cycles with PCSrc=10.
REQ-046 halt: HALT reached in 2 cycles; PCWre=0 and halted=1 for 20 further cycles; Reset returns to IF.

Source files
------------

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle MIPS-style control unit: IF/ID/EXE/MEM/WB FSM
// with memory timeout, sticky error flags and HALT state.
module multi_cycle_control_unit #(
    parameter int OPW         = 6,
    parameter int ALUOPW      = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [OPW-1:0]    opcode,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              PCWre,
    output logic              IRWre,
    output logic              ExtSel,
    output logic              RegOut,
    output logic              RegWre,
    output logic [ALUOPW-1:0] ALUOp,
    output logic              ALUSrcB,
    output logic              ALUM2Reg,
    output logic [1:0]        PCSrc,
    output logic              DataMemWr,
    output logic              DataMemRd,
    output logic [2:0]        state,
    output logic              halted,
    output logic              mem_err,
    output logic              illegal
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b101
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_err_q, mem_err_d;
    logic          illegal_q, illegal_d;

    logic op_add, op_addi, op_sub, op_ori, op_and, op_or;
    logic op_move, op_sw, op_lw, op_beq, op_bne, op_j, op_halt;
    logic op_legal;

    assign op_add  = (opcode == OPW'(6'b000000));
    assign op_addi = (opcode == OPW'(6'b000001));
    assign op_sub  = (opcode == OPW'(6'b000010));
    assign op_ori  = (opcode == OPW'(6'b010000));
    assign op_and  = (opcode == OPW'(6'b010001));
    assign op_or   = (opcode == OPW'(6'b010010));
    assign op_move = (opcode == OPW'(6'b100000));
    assign op_sw   = (opcode == OPW'(6'b100110));
    assign op_lw   = (opcode == OPW'(6'b100111));
    assign op_beq  = (opcode == OPW'(6'b110000));
    assign op_bne  = (opcode == OPW'(6'b110001));
    assign op_j    = (opcode == OPW'(6'b111000));
    assign op_halt = (opcode == OPW'(6'b111111));

    assign op_legal = op_add | op_addi | op_sub | op_ori | op_and
                    | op_or | op_move | op_sw | op_lw | op_beq
                    | op_bne | op_j | op_halt;

    // State, wait counter and sticky flags
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= S_IF;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state, counter and flag update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_err_d = mem_err_q;
        illegal_d = illegal_q;
        unique case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                if (!op_legal) begin
                    illegal_d = 1'b1;
                    state_d   = S_IF;
                end else if (op_halt) begin
                    state_d = S_HALT;
                end else if (op_j) begin
                    state_d = S_IF;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                if (op_beq | op_bne) begin
                    state_d = S_IF;
                end else if (op_sw | op_lw) begin
                    state_d = S_MEM;
                    cnt_d   = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = op_lw ? S_WB : S_IF;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d   = S_HALT;
                        mem_err_d = 1'b1;
                    end
                end
            end
            S_WB:   state_d = S_IF;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // Control outputs decoded from state and opcode
    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        ALUM2Reg  = 1'b0;
        PCSrc     = 2'b00;
        DataMemWr = 1'b0;
        DataMemRd = 1'b0;
        unique case (state_q)
            S_IF: IRWre = 1'b1;
            S_ID: begin
                if (op_j) begin
                    PCWre = 1'b1;
                    PCSrc = 2'b10;
                end else if (!op_legal) begin
                    PCWre = 1'b1;
                end
            end
            S_EXE: begin
                if (op_beq) begin
                    PCWre = 1'b1;
                    PCSrc = zero ? 2'b01 : 2'b00;
                end else if (op_bne) begin
                    PCWre = 1'b1;
                    PCSrc = zero ? 2'b00 : 2'b01;
                end
            end
            S_MEM: begin
                DataMemWr = op_sw;
                DataMemRd = op_lw;
                ALUM2Reg  = op_lw;
                PCWre     = op_sw & mem_ready;
            end
            S_WB: begin
                PCWre    = 1'b1;
                RegWre   = 1'b1;
                ALUM2Reg = op_lw;
            end
            default: ;
        endcase
        if (Reset) begin
            PCWre     = 1'b0;
            IRWre     = 1'b0;
            RegWre    = 1'b0;
            DataMemWr = 1'b0;
            DataMemRd = 1'b0;
        end
    end

    // Datapath selects held for the whole instruction
    always_comb begin
        ExtSel  = ~(op_ori | op_and | op_or);
        ALUSrcB = op_addi | op_ori | op_lw | op_sw;
        RegOut  = op_add | op_sub | op_and | op_or | op_move;
        unique case (1'b1)
            op_sub | op_beq | op_bne: ALUOp = ALUOPW'(3'b001);
            op_ori | op_or:           ALUOp = ALUOPW'(3'b011);
            op_and:                   ALUOp = ALUOPW'(3'b100);
            default:                  ALUOp = ALUOPW'(3'b000);
        endcase
    end

    assign state   = state_q;
    assign halted  = (state_q == S_HALT);
    assign mem_err = mem_err_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Directed bench for multi_cycle_control_unit: per-cycle table
// plus hand sequences for timeout, ready-wins and HALT.
module tb_multi_cycle_control_unit;

    localparam logic [5:0] ADD  = 6'b000000;
    localparam logic [5:0] LW   = 6'b100111;
    localparam logic [5:0] SW   = 6'b100110;
    localparam logic [5:0] ORI  = 6'b010000;
    localparam logic [5:0] ANDI = 6'b010001;
    localparam logic [5:0] BEQ  = 6'b110000;
    localparam logic [5:0] BNE  = 6'b110001;
    localparam logic [5:0] JMP  = 6'b111000;
    localparam logic [5:0] HLT  = 6'b111111;
    localparam logic [5:0] ILL  = 6'b000111;

    logic       CLK, Reset, zero, mem_ready;
    logic [5:0] opcode;
    logic       PCWre, IRWre, ExtSel, RegOut, RegWre;
    logic [2:0] ALUOp;
    logic       ALUSrcB, ALUM2Reg;
    logic [1:0] PCSrc;
    logic       DataMemWr, DataMemRd;
    logic [2:0] state;
    logic       halted, mem_err, illegal;

    multi_cycle_control_unit #(
        .OPW(6), .ALUOPW(3), .MEM_TIMEOUT(15)
    ) dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode),
        .zero(zero), .mem_ready(mem_ready),
        .PCWre(PCWre), .IRWre(IRWre), .ExtSel(ExtSel),
        .RegOut(RegOut), .RegWre(RegWre), .ALUOp(ALUOp),
        .ALUSrcB(ALUSrcB), .ALUM2Reg(ALUM2Reg), .PCSrc(PCSrc),
        .DataMemWr(DataMemWr), .DataMemRd(DataMemRd),
        .state(state), .halted(halted), .mem_err(mem_err),
        .illegal(illegal)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        z;
        logic        mr;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    // {state,PCWre,IRWre,RegWre,RegOut,ALUSrcB,ExtSel,ALUOp,
    //  ALUM2Reg,PCSrc,DataMemWr,DataMemRd,halted,mem_err,illegal}
    function automatic logic [19:0] actual();
        return {state, PCWre, IRWre, RegWre, RegOut, ALUSrcB,
                ExtSel, ALUOp, ALUM2Reg, PCSrc, DataMemWr,
                DataMemRd, halted, mem_err, illegal};
    endfunction

    function automatic void r(
        int rst, logic [5:0] op, int z, int mr,
        int st, int pcw, int irw, int rgw, int rgo, int asb,
        int ext, int aop, int m2r, int pcs, int dw, int dr,
        int hlt, int merr, int ill);
        vec_t v;
        v.rst = 1'(rst);
        v.op  = op;
        v.z   = 1'(z);
        v.mr  = 1'(mr);
        v.exp = {3'(st), 1'(pcw), 1'(irw), 1'(rgw), 1'(rgo),
                 1'(asb), 1'(ext), 3'(aop), 1'(m2r), 2'(pcs),
                 1'(dw), 1'(dr), 1'(hlt), 1'(merr), 1'(ill)};
        tbl.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act,
                       logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        zero = 1'b0;
        mem_ready = 1'b0;
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        opcode = ADD;
        zero = 1'b0;
        mem_ready = 1'b0;
        tick();

        // held in reset: enables forced low
        r(1,ADD,0,0, 0,0,0,0, 1,0,1,0, 0,0,0,0,0,0,0);
        // add
        r(0,ADD,0,0, 0,0,1,0, 1,0,1,0, 0,0,0,0,0,0,0);
        r(0,ADD,0,0, 1,0,0,0, 1,0,1,0, 0,0,0,0,0,0,0);
        r(0,ADD,0,0, 2,0,0,0, 1,0,1,0, 0,0,0,0,0,0,0);
        r(0,ADD,0,0, 4,1,0,1, 1,0,1,0, 0,0,0,0,0,0,0);
        // lw, ready on third MEM cycle
        r(0,LW,0,0, 0,0,1,0, 0,1,1,0, 0,0,0,0,0,0,0);
        r(0,LW,0,0, 1,0,0,0, 0,1,1,0, 0,0,0,0,0,0,0);
        r(0,LW,0,0, 2,0,0,0, 0,1,1,0, 0,0,0,0,0,0,0);
        r(0,LW,0,0, 3,0,0,0, 0,1,1,0, 1,0,0,1,0,0,0);
        r(0,LW,0,0, 3,0,0,0, 0,1,1,0, 1,0,0,1,0,0,0);
        r(0,LW,0,1, 3,0,0,0, 0,1,1,0, 1,0,0,1,0,0,0);
        r(0,LW,0,0, 4,1,0,1, 0,1,1,0, 1,0,0,0,0,0,0);
        // beq taken
        r(0,BEQ,1,0, 0,0,1,0, 0,0,1,1, 0,0,0,0,0,0,0);
        r(0,BEQ,1,0, 1,0,0,0, 0,0,1,1, 0,0,0,0,0,0,0);
        r(0,BEQ,1,0, 2,1,0,0, 0,0,1,1, 0,1,0,0,0,0,0);
        // bne not taken, then taken
        r(0,BNE,1,0, 0,0,1,0, 0,0,1,1, 0,0,0,0,0,0,0);
        r(0,BNE,1,0, 1,0,0,0, 0,0,1,1, 0,0,0,0,0,0,0);
        r(0,BNE,1,0, 2,1,0,0, 0,0,1,1, 0,0,0,0,0,0,0);
        r(0,BNE,0,0, 0,0,1,0, 0,0,1,1, 0,0,0,0,0,0,0);
        r(0,BNE,0,0, 1,0,0,0, 0,0,1,1, 0,0,0,0,0,0,0);
        r(0,BNE,0,0, 2,1,0,0, 0,0,1,1, 0,1,0,0,0,0,0);
        // sw, ready immediately
        r(0,SW,0,0, 0,0,1,0, 0,1,1,0, 0,0,0,0,0,0,0);
        r(0,SW,0,0, 1,0,0,0, 0,1,1,0, 0,0,0,0,0,0,0);
        r(0,SW,0,0, 2,0,0,0, 0,1,1,0, 0,0,0,0,0,0,0);
        r(0,SW,0,1, 3,1,0,0, 0,1,1,0, 0,0,1,0,0,0,0);
        // ori
        r(0,ORI,0,0, 0,0,1,0, 0,1,0,3, 0,0,0,0,0,0,0);
        r(0,ORI,0,0, 1,0,0,0, 0,1,0,3, 0,0,0,0,0,0,0);
        r(0,ORI,0,0, 2,0,0,0, 0,1,0,3, 0,0,0,0,0,0,0);
        r(0,ORI,0,0, 4,1,0,1, 0,1,0,3, 0,0,0,0,0,0,0);
        // and
        r(0,ANDI,0,0, 0,0,1,0, 1,0,0,4, 0,0,0,0,0,0,0);
        r(0,ANDI,0,0, 1,0,0,0, 1,0,0,4, 0,0,0,0,0,0,0);
        r(0,ANDI,0,0, 2,0,0,0, 1,0,0,4, 0,0,0,0,0,0,0);
        r(0,ANDI,0,0, 4,1,0,1, 1,0,0,4, 0,0,0,0,0,0,0);
        // undefined opcode, then j
        r(0,ILL,0,0, 0,0,1,0, 0,0,1,0, 0,0,0,0,0,0,0);
        r(0,ILL,0,0, 1,1,0,0, 0,0,1,0, 0,0,0,0,0,0,0);
        r(0,JMP,0,0, 0,0,1,0, 0,0,1,0, 0,0,0,0,0,0,1);
        r(0,JMP,0,0, 1,1,0,0, 0,0,1,0, 0,2,0,0,0,0,1);
        // lw aborted by reset mid-MEM
        r(0,LW,0,0, 0,0,1,0, 0,1,1,0, 0,0,0,0,0,0,1);
        r(0,LW,0,0, 1,0,0,0, 0,1,1,0, 0,0,0,0,0,0,1);
        r(0,LW,0,0, 2,0,0,0, 0,1,1,0, 0,0,0,0,0,0,1);
        r(0,LW,0,0, 3,0,0,0, 0,1,1,0, 1,0,0,1,0,0,1);
        r(1,LW,0,0, 3,0,0,0, 0,1,1,0, 1,0,0,0,0,0,1);
        r(0,LW,0,0, 0,0,1,0, 0,1,1,0, 0,0,0,0,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            Reset     = tbl[i].rst;
            opcode    = tbl[i].op;
            zero      = tbl[i].z;
            mem_ready = tbl[i].mr;
            #1;
            chk($sformatf("row%0d", i), 32'(actual()),
                32'(tbl[i].exp));
            tick();
        end

        // sw timeout after 15 MEM cycles
        do_reset();
        opcode = SW;
        tick(); tick(); tick();
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("to_state%0d", i), 32'(state), 3);
            chk($sformatf("to_wr%0d", i),
                32'({PCWre, DataMemWr}), 32'b01);
            tick();
        end
        chk("to_halt", 32'(state), 5);
        chk("to_flags", 32'({mem_err, halted, PCWre}), 32'b110);
        Reset = 1'b1;
        #1;
        chk("to_rst_irw", 32'(IRWre), 0);
        tick();
        Reset = 1'b0;
        #1;
        chk("to_clear", 32'({state, mem_err, IRWre}), 32'b000_0_1);

        // ready on the 15th MEM cycle wins
        opcode = SW;
        tick(); tick(); tick();
        for (int i = 0; i < 14; i++) tick();
        mem_ready = 1'b1;
        #1;
        chk("rw_pcw", 32'({state, PCWre}), 32'b011_1);
        tick();
        mem_ready = 1'b0;
        chk("rw_after", 32'({state, mem_err}), 32'b000_0);

        // counter restarts on the next MEM entry
        tick(); tick(); tick();
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("cl_state%0d", i), 32'(state), 3);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("cl_done", 32'({PCWre, mem_err}), 32'b10);
        tick();
        mem_ready = 1'b0;

        // halt
        do_reset();
        opcode = HLT;
        tick(); tick();
        chk("h_state", 32'(state), 5);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("h_hold%0d", i),
                32'({halted, PCWre, IRWre, RegWre, state}),
                32'b1000_101);
            tick();
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        chk("h_exit", 32'({state, halted}), 32'b000_0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
